oldland_memory: RTL

OLDLAND_MEMORY -- requirements
Module: oldland_memory

---
 rtl/oldland_memory.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/oldland_memory.sv
// Data-memory stage for the Oldland pipeline: IDLE/BUS controller, lane steering and writeback.
// Optional OLDLAND_MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a fault.
module oldland_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    input  logic [31:0] wr_val,
    input  logic        wr_result,
    input  logic [3:0]  rd_sel,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_val,
    output logic        d_wr_en,
    output logic        d_access,
    input  logic [31:0] d_data,
    input  logic        d_ack,
    input  logic        d_error,
    output logic [31:0] wb_val,
    output logic        wb_en,
    output logic [3:0]  wb_rd_sel,
    output logic        busy,
    output logic        fault
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr;
    logic [3:0]  r_bytesel;
    logic [31:0] r_wr_val;
    logic        r_wr_en;
    logic        r_access;
    logic        r_is_load;
    logic [1:0]  r_width;
    logic [1:0]  r_lane;
    logic [3:0]  r_rd_sel;
    logic        r_wr_result;
    logic [31:0] r_wb_val;
    logic        r_wb_en;
    logic [3:0]  r_wb_rd_sel;
    logic        r_fault;

    logic        w_req;
    logic        w_misaligned;
    logic        w_accept;
    logic [3:0]  w_bytesel;
    logic [31:0] w_store_data;
    logic [31:0] w_load_data;

    assign w_req = mem_load | mem_store;

`ifdef OLDLAND_MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((mem_width == 2'b01) && mar[0]) ||
                          (((mem_width == 2'b00) || (mem_width == 2'b11)) && (mar[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_accept = w_req & ~w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_BUS;
            ST_BUS:  if (d_ack)    w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Store data is replicated so every enabled lane carries the right bytes.
    always_comb begin
        w_bytesel    = 4'b1111;
        w_store_data = mdr;
        case (mem_width)
            2'b01: begin
                w_bytesel    = mar[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{mdr[15:0]}};
            end
            2'b10: begin
                w_bytesel    = 4'b0001 << mar[1:0];
                w_store_data = {4{mdr[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_load_data = d_data;
        case (r_width)
            2'b01: w_load_data = {16'h0000, r_lane[1] ? d_data[31:16] : d_data[15:0]};
            2'b10: begin
                case (r_lane)
                    2'b00:   w_load_data = {24'h000000, d_data[7:0]};
                    2'b01:   w_load_data = {24'h000000, d_data[15:8]};
                    2'b10:   w_load_data = {24'h000000, d_data[23:16]};
                    default: w_load_data = {24'h000000, d_data[31:24]};
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 32'h0;
            r_bytesel   <= 4'h0;
            r_wr_val    <= 32'h0;
            r_wr_en     <= 1'b0;
            r_access    <= 1'b0;
            r_is_load   <= 1'b0;
            r_width     <= 2'b00;
            r_lane      <= 2'b00;
            r_rd_sel    <= 4'h0;
            r_wr_result <= 1'b0;
            r_wb_val    <= 32'h0;
            r_wb_en     <= 1'b0;
            r_wb_rd_sel <= 4'h0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_wb_en <= 1'b0;
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_addr      <= {mar[31:2], 2'b00};
                            r_bytesel   <= w_bytesel;
                            r_wr_val    <= mem_store ? w_store_data : 32'h0;
                            r_wr_en     <= mem_store;
                            r_access    <= 1'b1;
                            r_is_load   <= mem_load;
                            r_width     <= mem_width;
                            r_lane      <= mar[1:0];
                            r_rd_sel    <= rd_sel;
                            r_wr_result <= wr_result;
                        end
                    end else begin
                        r_wb_val    <= wr_val;
                        r_wb_en     <= wr_result;
                        r_wb_rd_sel <= rd_sel;
                    end
                end
                ST_BUS: begin
                    r_wb_en <= 1'b0;
                    if (d_ack) begin
                        // Bus outputs drop to zero as soon as the controller is idle again.
                        r_addr    <= 32'h0;
                        r_bytesel <= 4'h0;
                        r_wr_val  <= 32'h0;
                        r_wr_en   <= 1'b0;
                        r_access  <= 1'b0;
                        if (d_error) begin
                            r_fault <= 1'b1;
                        end else if (r_is_load) begin
                            r_wb_en     <= r_wr_result;
                            r_wb_val    <= w_load_data;
                            r_wb_rd_sel <= r_rd_sel;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign d_addr    = r_addr;
    assign d_bytesel = r_bytesel;
    assign d_wr_val  = r_wr_val;
    assign d_wr_en   = r_wr_en;
    assign d_access  = r_access;
    assign wb_val    = r_wb_val;
    assign wb_en     = r_wb_en;
    assign wb_rd_sel = r_wb_rd_sel;
    assign busy      = (r_state != ST_IDLE);
    assign fault     = r_fault;

endmodule
